// File: rtl/supercar_pkg.sv
// Shared definitions for the Supercar input path: key FSM state encoding
// and default timing constants for a 50 MHz CLOCK_50.
package supercar_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HELD   = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    localparam int CLK_HZ                = 50_000_000;
    localparam int DEF_DEBOUNCE_CYCLES   = CLK_HZ / 50;
    localparam int DEF_REPEAT_DELAY      = CLK_HZ / 2;
    localparam int DEF_REPEAT_PERIOD     = CLK_HZ / 10;

    // Width of a down-counter that must hold the larger of two reload values minus one.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, debouncer, and press/hold/repeat FSM.
// All outputs are registered and active-high.
module key_channel
    import supercar_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    input  logic repeat_en,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = timer_width(REPEAT_DELAY, REPEAT_PERIOD);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic          accept;
    logic          accept_press;
    logic          accept_release;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign accept         = (sync2 != stable) && (count == CW'(DEBOUNCE_CYCLES - 1));
    assign accept_press   = accept && !sync2;
    assign accept_release = accept && sync2;

    // Any cycle that agrees with the accepted level restarts the stability count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b1;
            count  <= '0;
        end else begin
            if (sync2 == stable || accept) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
            if (accept) begin
                stable <= sync2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            key_press   <= accept_press;
            key_release <= accept_release;
            key_repeat  <= 1'b0;
            if (accept) begin
                key_level <= ~sync2;
            end
            // A release takes priority over a repeat expiring on the same edge.
            if (accept_release) begin
                state <= IDLE;
                timer <= '0;
            end else if (accept_press) begin
                state <= HELD;
                timer <= TW'(REPEAT_DELAY - 1);
            end else begin
                case (state)
                    HELD: begin
                        if (timer == '0) begin
                            if (repeat_en) begin
                                key_repeat <= 1'b1;
                                state      <= REPEAT;
                                timer      <= TW'(REPEAT_PERIOD - 1);
                            end
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (timer == '0) begin
                            key_repeat <= 1'b1;
                            timer      <= TW'(REPEAT_PERIOD - 1);
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    IDLE: begin
                        timer <= '0;
                    end
                    default: begin
                        state <= IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Conditions the raw active-low DE-board KEY buttons into clean levels and
// single-cycle press, release and auto-repeat pulses for the Supercar block.
module key_conditioner
    import supercar_pkg::*;
#(
    parameter int                N_KEYS          = 4,
    parameter int                DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int                REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int                REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter logic [N_KEYS-1:0] REPEAT_EN       = 4'b1100
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] KEY_LEVEL,
    output logic [N_KEYS-1:0] KEY_PRESS,
    output logic [N_KEYS-1:0] KEY_RELEASE,
    output logic [N_KEYS-1:0] KEY_REPEAT
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_channel (
            .clk         (CLOCK_50),
            .rst         (RESET),
            .key_n       (KEY[i]),
            .repeat_en   (REPEAT_EN[i]),
            .key_level   (KEY_LEVEL[i]),
            .key_press   (KEY_PRESS[i]),
            .key_release (KEY_RELEASE[i]),
            .key_repeat  (KEY_REPEAT[i])
        );
    end

endmodule
